divrem: RTL and testbench
=========================

Name: divrem

Overview:
- Iterative 32-bit integer divider implementing the RISC-V M-extension DIV, DIVU, REM and REMU operations.
- It is the inverse-direction companion to the pipelined multiply units.
- It sits beside the multipliers in the execute stage and uses a start/busy/done handshake instead of a fixed pipeline.
- It retires one quotient bit per cycle with a radix-2 restoring algorithm.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- op  in  2  operation: 00=DIV, 01=DIVU, 10=REM, 11=REMU
- r1  in  32  dividend; sampled with start
- r2  in  32  divisor; sampled with start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when rd is valid
- rd  out  32  result; holds its value until the next done

Behaviour:
- Reset is synchronous and active-high. It has priority over everything else and may arrive mid-operation, in which case the operation is aborted.
  - Reset values: state=IDLE, busy=0, done=0, rd=0, counter=0.
- States:
  - IDLE: wait for start.
  - CALC: 32 iterations.
  - FIN: sign fix-up and result write.
- IDLE -> CALC: at an edge with start=1 (edge E0).
  - Latch op and the magnitudes |r1| and |r2|. Operands are treated as two's complement only for op=00/10; otherwise they are unsigned.
  - Latch the quotient sign (r1[31]^r2[31]) and the remainder sign (r1[31]); both are forced to 0 for unsigned ops.
  - Latch the div-by-zero flag (r2==0) and the signed-overflow flag (signed op, r1=0x80000000, r2=0xFFFFFFFF).
  - Clear the 33-bit partial remainder; load the quotient register with |r1|; counter=0.
- CALC, one edge per bit (E1..E32), MSB first:
  - Shift {rem, quo} left by 1.
  - Trial subtract rem - |r2| at 33-bit width.
  - If non-negative: rem = difference and quo[0]=1. Otherwise keep rem and quo[0]=0.
  - counter increments; after the 32nd iteration go to FIN.
- FIN -> IDLE at edge E33: rd is written and done=1 for exactly that one cycle.
  - Quotient result: negate if the quotient sign is set.
  - Remainder result: negate if the remainder sign is set.
  - Div by zero overrides: quotient=0xFFFFFFFF; remainder=r1 as sampled.
  - Signed overflow overrides: quotient=0x80000000; remainder=0.
  - rd = quotient for op 00/01; remainder for op 10/11.
- Latency:
  - Fixed at 33 cycles from the start edge to done, for all operands including the special cases.
  - busy=1 from after E0 until state returns to IDLE, so busy=0 in the cycle where done=1.
- Back-to-back:
  - start may be asserted in the done cycle; it is accepted at that edge, and the next result arrives 33 cycles later.
  - start while busy=1 is ignored, and no request is queued.
  - done is never asserted without a preceding accepted start.
- Operand stability: r1, r2 and op are don't-care after the start edge; all needed values are latched internally.
- Width rules:
  - The internal remainder is 33 bits, so the trial subtract never overflows.
  - Magnitude of 0x80000000 = 0x80000000 (unsigned interpretation of the latched magnitude).

Test Plan:
- DIVU, r1=100, r2=7, start one cycle -> busy high for 33 cycles, then done pulse; rd=14. REMU with the same operands -> rd=2.
- DIV with r1=-7 (0xFFFFFFF9), r2=2 -> rd=0xFFFFFFFD (-3). REM with the same operands -> rd=0xFFFFFFFF (-1), i.e. the remainder takes the dividend's sign.
- Divide by zero, r1=0x12345678, r2=0: DIV and DIVU -> rd=0xFFFFFFFF; REM and REMU -> rd=0x12345678. Latency is still 33 cycles.
- Overflow, DIV r1=0x80000000, r2=0xFFFFFFFF -> rd=0x80000000. REM with the same operands -> rd=0. DIVU with the same operands -> rd=0.
- Handshake: a second start while busy is ignored (exactly one done, rd unchanged by it). A start asserted in the done cycle is accepted, giving the next done 33 cycles later.
- Reset asserted at iteration 10 -> the next cycle shows busy=0, done=0, rd=0, and no done follows. A fresh DIVU 0xFFFFFFFF/1 then gives rd=0xFFFFFFFF.

Source files
------------

// File: rtl/divrem.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, 33 cycles start-to-done.
// One request in flight: start is ignored while busy and is never queued.
module divrem #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] r1,
    input  logic [XLEN-1:0] r2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rd
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic             r_op_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_ovf;
    logic [XLEN-1:0]  r_dvd_raw;
    logic [XLEN-1:0]  r_dvs;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic             r_done;
    logic [XLEN-1:0]  r_rd;

    logic             w_sgn;
    logic             w_neg1;
    logic             w_neg2;
    logic [XLEN-1:0]  w_abs1;
    logic [XLEN-1:0]  w_abs2;
    logic             w_ovf;
    logic             w_last;
    logic [XLEN:0]    w_shift;
    logic [XLEN:0]    w_diff;
    logic             w_ge;
    logic [XLEN-1:0]  w_q_fix;
    logic [XLEN-1:0]  w_r_fix;
    logic [XLEN-1:0]  w_q_res;
    logic [XLEN-1:0]  w_r_res;
    logic [XLEN-1:0]  w_result;

    // Operand conditioning at the start edge.
    assign w_sgn  = ~op[0];
    assign w_neg1 = w_sgn & r1[XLEN-1];
    assign w_neg2 = w_sgn & r2[XLEN-1];
    assign w_abs1 = w_neg1 ? (~r1 + 1'b1) : r1;
    assign w_abs2 = w_neg2 ? (~r2 + 1'b1) : r2;
    assign w_ovf  = w_sgn && (r1 == {1'b1, {(XLEN-1){1'b0}}}) && (r2 == {XLEN{1'b1}});

    // The running remainder stays below the divisor, so its shifted form fits XLEN+1 bits.
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_ge    = ~w_diff[XLEN];
    assign w_last  = (r_cnt == CNT_W'(XLEN - 1));

    assign w_q_fix  = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_r_fix  = r_neg_r ? (~r_rem + 1'b1) : r_rem;
    assign w_q_res  = r_dz  ? {XLEN{1'b1}} :
                      r_ovf ? {1'b1, {(XLEN-1){1'b0}}} : w_q_fix;
    assign w_r_res  = r_dz  ? r_dvd_raw :
                      r_ovf ? {XLEN{1'b0}} : w_r_fix;
    assign w_result = r_op_rem ? w_r_res : w_q_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CALC;
            S_CALC:  if (w_last) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_op_rem  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
            r_ovf     <= 1'b0;
            r_dvd_raw <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_done    <= 1'b0;
            r_rd      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op_rem  <= op[1];
                        r_neg_q   <= w_neg1 ^ w_neg2;
                        r_neg_r   <= w_neg1;
                        r_dz      <= (r2 == '0);
                        r_ovf     <= w_ovf;
                        r_dvd_raw <= r1;
                        r_dvs     <= w_abs2;
                        r_rem     <= '0;
                        r_quo     <= w_abs1;
                        r_cnt     <= '0;
                    end
                end
                S_CALC: begin
                    r_rem <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                    r_quo <= {r_quo[XLEN-2:0], w_ge};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIN: begin
                    r_rd   <= w_result;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign rd   = r_rd;

endmodule

// File: tb/tb_divrem.sv
// Randomized and directed checks of divrem against an arithmetic reference model.
module tb_divrem;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        busy;
    logic        done;
    logic [31:0] rd;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Model state: remaining cycles of the in-flight request (0 = idle).
    int          m_left = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_rd = '0;
    logic        m_done = 1'b0;

    divrem dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .r1    (r1),
        .r2    (r2),
        .busy  (busy),
        .done  (done),
        .rd    (rd)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_res(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f[1] ? 32'd0 : 32'h8000_0000;
        if (!f[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return f[1] ? r : q;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_rd   = '0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_rd   = m_pend;
                end
            end else if (start) begin
                m_left = 33;
                m_pend = ref_res(op, r1, r2);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_left != 0));
            check("done", 32'(done), 32'(m_done));
            check("rd", rd, m_rd);
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one request at the current negedge and wait for its done; checks rd and latency.
    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        int k;
        start = 1'b1; op = f; r1 = a; r2 = b;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); r1 = $urandom; r2 = $urandom;
        k = 1;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({name, "_lat"}, 32'(k - 1), 32'd33);
        check(name, rd, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; r1 = '0; r2 = '0;

        // Pin the model with hand-computed values.
        check("model_divu", ref_res(2'b01, 32'd100, 32'd7), 32'd14);
        check("model_div_neg", ref_res(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        check("model_rem_neg", ref_res(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check("model_remu_dz", ref_res(2'b11, 32'h1234_5678, 32'd0), 32'h1234_5678);

        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rd", rd, 32'd0);
        rst = 1'b0;

        // Directed cases, issued back to back (each start lands in the previous done cycle).
        run_op(2'b01, 32'd100, 32'd7, 32'd14, "divu");
        run_op(2'b11, 32'd100, 32'd7, 32'd2, "remu");
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_neg");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_neg");
        run_op(2'b00, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, "div_dz");
        run_op(2'b01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, "divu_dz");
        run_op(2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, "rem_dz");
        run_op(2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, "remu_dz");
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf");
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "divu_ovf");

        // A start while busy must be ignored; the per-cycle compare catches any extra done.
        @(negedge clk);
        start = 1'b1; op = 2'b01; r1 = 32'd50; r2 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'b01; r1 = 32'd9; r2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("busy_ignored_rd", rd, 32'd10);

        // Reset during iteration 10 aborts the request.
        start = 1'b1; op = 2'b01; r1 = 32'd1000; r2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd", rd, 32'd0);
        repeat (40) @(negedge clk);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, "divu_after_rst");

        // Random traffic: sporadic starts (some while busy, some in done cycles) and rare resets.
        for (int i = 0; i < 6000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom);
            r1    = pick();
            r2    = pick();
            rst   = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        start = 1'b0; rst = 1'b0;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
